if_id_stage: RTL and testbench

Instruction fetch stage plus IF/ID pipeline register for the RISC-V core. It sequences PC-addressed requests to instruction memory with at most one request outstanding. It latches each returned instruction with its PC into the ID stage, and presents `id_opcode` directly to the main decoder's `Opcode` input. It honours hazard stalls and branch/jump redirects from EX, discarding any in-flight wrong-path fetch.

---
 rtl/if_id_stage.sv | 140 ++++++++++++++
 tb/tb_if_id_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Instruction fetch sequencer plus IF/ID pipeline register, one fetch outstanding at most.
// Define IF_ID_NOP_BUBBLE_EN to make the bubble word addi x0,x0,0 instead of all-zeros.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode
);

`ifdef IF_ID_NOP_BUBBLE_EN
  localparam logic [31:0] Bubble = 32'h0000_0013;
`else
  localparam logic [31:0] Bubble = 32'h0000_0000;
`endif

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StDrop = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_hold;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_id_valid_nxt;
  logic [31:0] w_id_pc_nxt;
  logic [31:0] w_id_instr_nxt;
  logic [31:0] w_hold_nxt;
  logic        w_fire;
  logic [31:0] w_pc_inc;

  assign imem_req_valid = (r_state == StReq);
  assign imem_addr      = r_pc;
  assign w_fire         = imem_req_valid & imem_req_ready;
  assign w_pc_inc       = r_pc + 32'd4;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_valid_nxt = r_id_valid;
    w_id_pc_nxt    = r_id_pc;
    w_id_instr_nxt = r_id_instr;
    w_hold_nxt     = r_hold;

    // ID consumes its instruction every unstalled cycle; a load below overrides this.
    if (!stall) begin
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = Bubble;
    end

    if (redirect) begin
      w_pc_nxt       = {redirect_pc[31:2], 2'b00};
      w_id_valid_nxt = 1'b0;
      w_id_instr_nxt = Bubble;
      case (r_state)
        StReq:   w_state_nxt = w_fire ? StDrop : StReq;
        StWait:  w_state_nxt = imem_rsp_valid ? StReq : StDrop;
        StDrop:  w_state_nxt = imem_rsp_valid ? StReq : StDrop;
        default: w_state_nxt = StReq;
      endcase
    end else begin
      case (r_state)
        StIdle: w_state_nxt = StReq;
        StReq: begin
          if (w_fire) w_state_nxt = StWait;
        end
        StWait: begin
          if (imem_rsp_valid) begin
            if (!stall) begin
              w_id_valid_nxt = 1'b1;
              w_id_pc_nxt    = r_pc;
              w_id_instr_nxt = imem_rsp_data;
              w_pc_nxt       = w_pc_inc;
              w_state_nxt    = StReq;
            end else begin
              w_hold_nxt  = imem_rsp_data;
              w_state_nxt = StHold;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            w_id_valid_nxt = 1'b1;
            w_id_pc_nxt    = r_pc;
            w_id_instr_nxt = r_hold;
            w_pc_nxt       = w_pc_inc;
            w_state_nxt    = StReq;
          end
        end
        StDrop: begin
          // Wrong-path response is swallowed here.
          if (imem_rsp_valid) w_state_nxt = StReq;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0000_0000;
      r_id_instr <= Bubble;
      r_hold     <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_opcode = r_id_instr[6:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed testbench for if_id_stage: fetch sequencing, stall hold, redirect/drop, reset.
module tb_if_id_stage;

`ifdef IF_ID_NOP_BUBBLE_EN
  localparam logic [31:0] Bubble = 32'h0000_0013;
`else
  localparam logic [31:0] Bubble = 32'h0000_0000;
`endif

  logic        clk;
  logic        reset_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;

  logic        w2_req_valid;
  logic [31:0] w2_addr;
  logic        w2_id_valid;
  logic [31:0] w2_id_pc;
  logic [31:0] w2_id_instr;
  logic [6:0]  w2_id_opcode;

  int checks = 0;
  int errors = 0;

  if_id_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode)
  );

  // Second instance sees identical stimulus; only its wrap-around addresses are checked.
  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (w2_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (w2_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_valid       (w2_id_valid),
    .id_pc          (w2_id_pc),
    .id_instr       (w2_id_instr),
    .id_opcode      (w2_id_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs for the next rising edge, then return at the following falling edge.
  task automatic tick(input logic rv, input logic [31:0] rd, input logic st,
                      input logic rdr, input logic [31:0] rpc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    stall          = st;
    redirect       = rdr;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_instr", id_instr, Bubble);
    check("rst_addr", imem_addr, 32'h0);

    // Basic fetch stream, zero-wait memory
    reset_n = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);              // IDLE -> REQ
    check("f0_req_valid", 32'(imem_req_valid), 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    check("wrap_addr0", w2_addr, 32'hFFFF_FFFC);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);              // accepted -> WAIT
    check("f0_wait_req", 32'(imem_req_valid), 32'd0);
    tick(1'b1, 32'h0000_0093, 1'b0, 1'b0, 32'h0);      // load pc 0
    check("f0_id_valid", 32'(id_valid), 32'd1);
    check("f0_id_pc", id_pc, 32'h0);
    check("f0_opcode", 32'(id_opcode), 32'h13);
    check("f1_addr", imem_addr, 32'h4);
    check("f1_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_id_pc", w2_id_pc, 32'hFFFF_FFFC);
    check("wrap_addr1", w2_addr, 32'h0000_0000);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("f1_id_consumed", 32'(id_valid), 32'd0);
    tick(1'b1, 32'h0000_0093, 1'b0, 1'b0, 32'h0);      // load pc 4
    check("f1_id_valid", 32'(id_valid), 32'd1);
    check("f1_id_pc", id_pc, 32'h4);
    check("f2_addr", imem_addr, 32'h8);

    // Stall 3 cycles; response arrives in WAIT and goes to the hold buffer
    tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("st0_id_valid", 32'(id_valid), 32'd1);
    check("st0_id_pc", id_pc, 32'h4);
    tick(1'b1, 32'h00A0_0513, 1'b1, 1'b0, 32'h0);
    check("st1_id_instr", id_instr, 32'h0000_0093);
    check("st1_id_pc", id_pc, 32'h4);
    check("st1_hold_req", 32'(imem_req_valid), 32'd0);
    tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("st2_id_valid", 32'(id_valid), 32'd1);
    check("st2_hold_req", 32'(imem_req_valid), 32'd0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);              // release stall
    check("st_rel_instr", id_instr, 32'h00A0_0513);
    check("st_rel_id_pc", id_pc, 32'h8);
    check("st_rel_valid", 32'(id_valid), 32'd1);
    check("st_rel_addr", imem_addr, 32'hC);
    check("st_rel_req", 32'(imem_req_valid), 32'd1);

    // Redirect while in WAIT, wrong-path response arrives two cycles later
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);              // -> WAIT
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);      // -> DROP
    check("rd_drop_req", 32'(imem_req_valid), 32'd0);
    check("rd_addr", imem_addr, 32'h100);
    check("rd_id_valid", 32'(id_valid), 32'd0);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rd_drop_hold", 32'(imem_req_valid), 32'd0);
    tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);      // discarded
    check("rd_after_drop_req", 32'(imem_req_valid), 32'd1);
    check("rd_after_drop_addr", imem_addr, 32'h100);
    check("rd_discard_valid", 32'(id_valid), 32'd0);
    check("rd_discard_instr", id_instr, Bubble);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_0037, 1'b0, 1'b0, 32'h0);
    check("rd_tgt_valid", 32'(id_valid), 32'd1);
    check("rd_tgt_pc", id_pc, 32'h100);
    check("rd_tgt_opcode", 32'(id_opcode), 32'h37);
    check("rd_next_addr", imem_addr, 32'h104);

    // Redirect + response + stall in the same cycle
    tick(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);              // -> WAIT, ID held valid
    check("rs_pre_valid", 32'(id_valid), 32'd1);
    tick(1'b1, 32'h0BAD_0013, 1'b1, 1'b1, 32'h0000_0200);
    check("rs_flush_valid", 32'(id_valid), 32'd0);
    check("rs_flush_instr", id_instr, Bubble);
    check("rs_no_drop_req", 32'(imem_req_valid), 32'd1);
    check("rs_addr", imem_addr, 32'h200);
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    check("rs_tgt_pc", id_pc, 32'h200);
    check("rs_tgt_valid", 32'(id_valid), 32'd1);

    // Redirect in REQ without handshake reissues at the target
    imem_req_ready = 1'b0;
    tick(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0302);
    check("rq_req", 32'(imem_req_valid), 32'd1);
    check("rq_addr", imem_addr, 32'h300);
    imem_req_ready = 1'b1;

    // Reset mid-WAIT, stale response right after release
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);              // -> WAIT
    check("mr_wait_req", 32'(imem_req_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mr_async_addr", imem_addr, 32'h0);
    check("mr_async_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, 32'h0BAD_0093, 1'b0, 1'b0, 32'h0);      // rsp seen in IDLE
    check("mr_stale_valid", 32'(id_valid), 32'd0);
    check("mr_stale_instr", id_instr, Bubble);
    check("mr_stale_id_pc", id_pc, 32'h0);
    check("mr_req", 32'(imem_req_valid), 32'd1);
    check("mr_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
